// File: rtl/gpu_dispatch_pkg.sv
// Shared idle codes and default widths for the task dispatcher.
// Optional statistics counters are enabled with DISPATCH_STATS_EN.
package gpu_dispatch_pkg;

  localparam int PC_W  = 16;
  localparam int TID_W = 4;

  typedef logic [1:0] idle_t;

  localparam idle_t IDLE_GO   = 2'd0;
  localparam idle_t IDLE_WAIT = 2'd1;
  localparam idle_t IDLE_HALT = 2'd2;

endpackage

// File: rtl/task_dispatcher_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the core
// after the last accepted grantee.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt;
  logic [PW-1:0] idx;

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    gnt = '0;
    nxt = ptr;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        nxt = PW'((int'(ptr) + k + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && |gnt) begin
      ptr <= nxt;
    end
  end

endmodule

// File: rtl/task_dispatcher.sv
// Task FIFO, entry-PC table and round-robin new-PC grants for cores.
// DISPATCH_STATS_EN adds saturating grant/drop counters.
module task_dispatcher #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int PC_W       = gpu_dispatch_pkg::PC_W,
  parameter int TID_W      = gpu_dispatch_pkg::TID_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tbl_wen,
  input  logic [TID_W-1:0]           tbl_addr,
  input  logic [PC_W-1:0]            tbl_data,
  input  logic                       start,
  input  logic [TID_W-1:0]           start_tid,
  input  logic [NUM_CORES-1:0]       req,
  input  logic [NUM_CORES-1:0]       q_wen,
  input  logic [NUM_CORES*TID_W-1:0] q_num,
  output logic [NUM_CORES*PC_W-1:0]  new_pc,
  output logic [NUM_CORES*2-1:0]     idle,
  output logic                       done,
  output logic                       overflow
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                stat_grants,
  output logic [15:0]                stat_drops
`endif
);

  import gpu_dispatch_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [PC_W-1:0]      tbl [2**TID_W];
  logic [TID_W-1:0]     fifo [FIFO_DEPTH];
  logic [AW:0]          wptr;
  logic [AW:0]          rptr;
  logic [AW:0]          count;
  logic                 empty;
  logic                 full;

  logic [TID_W-1:0]     hold [NUM_CORES];
  logic [NUM_CORES-1:0] hold_v;
  logic [NUM_CORES-1:0] pend;
  logic [NUM_CORES-1:0] gnt;
  logic [NUM_CORES-1:0] drain;
  logic [NUM_CORES-1:0] hv_drop;

  logic [PC_W-1:0]      pc_q [NUM_CORES];
  idle_t                idle_q [NUM_CORES];
  logic                 done_q;
  logic                 ovf_q;

  logic                 push;
  logic                 pop;
  logic                 start_drop;
  logic                 cond;
  logic [TID_W-1:0]     push_tid;
  logic [PC_W-1:0]      head_pc;

  assign count   = wptr - rptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign head_pc = tbl[fifo[rptr[AW-1:0]]];
  assign pop     = |gnt;
  assign hv_drop = q_wen & hold_v;

  rr_arbiter #(
    .N(NUM_CORES)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (pend & {NUM_CORES{~empty}}),
    .accept (pop),
    .gnt    (gnt)
  );

  // Start outranks the holds; otherwise lowest full hold drains.
  always_comb begin
    drain      = '0;
    push       = 1'b0;
    push_tid   = start_tid;
    start_drop = start & full;
    if (start) begin
      push = ~full;
    end else if (!full) begin
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
        if (hold_v[i]) begin
          drain    = '0;
          drain[i] = 1'b1;
          push     = 1'b1;
          push_tid = hold[i];
        end
      end
    end
  end

  assign cond = empty && !(|hold_v) && !(|q_wen)
             && !start && (&pend);

  always_ff @(posedge clk) begin
    if (tbl_wen) begin
      tbl[tbl_addr] <= tbl_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wptr[AW-1:0]] <= push_tid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      hold_v <= '0;
      pend   <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        hold[i]   <= '0;
        pc_q[i]   <= '0;
        idle_q[i] <= IDLE_WAIT;
      end
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      hold_v <= (hold_v & ~drain) | (q_wen & ~hold_v);
      pend   <= (pend | (req & {NUM_CORES{~done_q}})) & ~gnt;
      if (start_drop || |hv_drop) ovf_q <= 1'b1;
      if (start)     done_q <= 1'b0;
      else if (cond) done_q <= 1'b1;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (q_wen[i] && !hold_v[i]) begin
          hold[i] <= q_num[i*TID_W +: TID_W];
        end
        if (cond) begin
          idle_q[i] <= IDLE_HALT;
        end else if (gnt[i]) begin
          idle_q[i] <= IDLE_GO;
          pc_q[i]   <= head_pc;
        end else if (idle_q[i] == IDLE_GO) begin
          idle_q[i] <= IDLE_WAIT;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_out
    assign new_pc[g*PC_W +: PC_W] = pc_q[g];
    assign idle[g*2 +: 2]         = idle_q[g];
  end

  assign done     = done_q;
  assign overflow = ovf_q;

`ifdef DISPATCH_STATS_EN
  logic [16:0] n_drop;
  logic [16:0] drop_sum;

  always_comb begin
    n_drop = 17'(start_drop);
    for (int i = 0; i < NUM_CORES; i++) begin
      n_drop = n_drop + 17'(hv_drop[i]);
    end
    drop_sum = {1'b0, stat_drops} + n_drop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_drops  <= '0;
    end else begin
      if (pop && stat_grants != '1) begin
        stat_grants <= stat_grants + 1'b1;
      end
      stat_drops <= drop_sum[16] ? '1 : drop_sum[15:0];
    end
  end
`endif

endmodule
